// File: rtl/sim_time_pkg.sv
// Shared types and default timebase constants for the sim_time counter slice.
package sim_time_pkg;

    typedef logic [63:0] time_t;

    localparam int unsigned PERIOD_FINE_DEF = 1000;
    localparam int unsigned COARSE_DIV_DEF  = 1000;

    function automatic logic params_ok(input int unsigned period_fine, input int unsigned coarse_div);
        return (period_fine != 0) && (coarse_div != 0) &&
               (period_fine <= coarse_div) && (coarse_div <= 32'h7fff_ffff);
    endfunction

endpackage

// File: rtl/sim_time_div.sv
// Coarse time counter: accumulates fine periods in a remainder and carries whole coarse units.
module sim_time_div
    import sim_time_pkg::*;
#(
    parameter int unsigned PERIOD_FINE = PERIOD_FINE_DEF,
    parameter int unsigned COARSE_DIV  = COARSE_DIV_DEF
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  en,
    input  logic  clr,
    output time_t coarse
);

    logic [31:0] rem;
    logic [32:0] sum;
    logic        roll;

    // PERIOD_FINE never exceeds COARSE_DIV, so at most one carry per cycle.
    always_comb begin
        sum  = {1'b0, rem} + 33'(PERIOD_FINE);
        roll = (sum >= 33'(COARSE_DIV));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            coarse <= '0;
            rem    <= '0;
        end else if (clr) begin
            coarse <= '0;
            rem    <= '0;
        end else if (en) begin
            if (roll) begin
                coarse <= coarse + 64'd1;
                rem    <= 32'(sum - 33'(COARSE_DIV));
            end else begin
                rem    <= sum[31:0];
            end
        end
    end

endmodule

// File: rtl/sim_time.sv
// Free-running simulation timebase with fine/coarse readout, snapshot capture and wrap flag.
module sim_time
    import sim_time_pkg::*;
#(
    parameter int unsigned PERIOD_FINE = PERIOD_FINE_DEF,
    parameter int unsigned COARSE_DIV  = COARSE_DIV_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic        fine_sel_i,
    input  logic        req_i,
    output time_t       now_o,
    output time_t       snap_o,
    output logic [31:0] snap_hi_o,
    output logic [31:0] snap_lo_o,
    output logic        snap_valid_o,
    output logic        wrap_o
);

    if (!params_ok(PERIOD_FINE, COARSE_DIV)) begin : g_bad_params
        $error("sim_time: illegal PERIOD_FINE/COARSE_DIV combination");
    end

    time_t       fine;
    time_t       coarse;
    logic [64:0] fine_sum;
    logic        wrap;
    time_t       snap_p1;
    logic        vld_p1;

    assign fine_sum = {1'b0, fine} + 65'(PERIOD_FINE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fine <= '0;
            wrap <= 1'b0;
        end else if (clr_i) begin
            fine <= '0;
        end else if (en_i) begin
            fine <= fine_sum[63:0];
            if (fine_sum[64]) begin
                wrap <= 1'b1;
            end
        end
    end

    sim_time_div #(
        .PERIOD_FINE (PERIOD_FINE),
        .COARSE_DIV  (COARSE_DIV)
    ) u_div (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (en_i),
        .clr    (clr_i),
        .coarse (coarse)
    );

    assign now_o = fine_sel_i ? fine : coarse;

    // stage p1: snapshot of the pre-edge live value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= req_i;
            if (req_i) begin
                snap_p1 <= now_o;
            end
        end
    end

    assign snap_o       = snap_p1;
    assign snap_hi_o    = snap_p1[63:32];
    assign snap_lo_o    = snap_p1[31:0];
    assign snap_valid_o = vld_p1;
    assign wrap_o       = wrap;

endmodule

// File: tb/tb_sim_time.sv
// Directed bench for sim_time: a default instance and a 400/1000 instance share stimulus.
module tb_sim_time;
    import sim_time_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic en = 1'b0, clr = 1'b0, sel = 1'b0, req = 1'b0;

    time_t       now_a, snap_a, now_b, snap_b;
    logic [31:0] hi_a, lo_a, hi_b, lo_b;
    logic        vld_a, wrap_a, vld_b, wrap_b;

    int total = 0;
    int bad   = 0;

    sim_time dut_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .fine_sel_i(sel), .req_i(req),
        .now_o(now_a), .snap_o(snap_a), .snap_hi_o(hi_a), .snap_lo_o(lo_a),
        .snap_valid_o(vld_a), .wrap_o(wrap_a)
    );

    sim_time #(.PERIOD_FINE(400), .COARSE_DIV(1000)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .fine_sel_i(sel), .req_i(req),
        .now_o(now_b), .snap_o(snap_b), .snap_hi_o(hi_b), .snap_lo_o(lo_b),
        .snap_valid_o(vld_b), .wrap_o(wrap_b)
    );

    // Model: n counts enabled edges since clear/reset; coarse is n*P/DIV, instance A fine tracked for preload.
    longint unsigned n = 0;
    time_t m_fine_a = '0, m_snap_a = '0, m_snap_b = '0;
    logic  m_vld_a = 1'b0, m_vld_b = 1'b0, m_wrap_a = 1'b0;
    logic  preload_ev = 1'b0;
    time_t preload_val = '0;

    function automatic time_t m_now_a();
        return sel ? m_fine_a : time_t'(n);
    endfunction

    function automatic time_t m_now_b();
        return sel ? time_t'(n * 400) : time_t'((n * 400) / 1000);
    endfunction

    always @(posedge clk or negedge rst_n or posedge preload_ev) begin
        if (!rst_n) begin
            n = 0; m_fine_a = '0; m_snap_a = '0; m_snap_b = '0;
            m_vld_a = 1'b0; m_vld_b = 1'b0; m_wrap_a = 1'b0;
        end else if (preload_ev) begin
            m_fine_a = preload_val;
        end else begin
            m_vld_a = req;
            m_vld_b = req;
            if (req) begin
                m_snap_a = m_now_a();
                m_snap_b = m_now_b();
            end
            if (clr) begin
                m_fine_a = '0;
                n = 0;
            end else if (en) begin
                if (m_fine_a > 64'hFFFF_FFFF_FFFF_FFFF - 64'd1000) m_wrap_a = 1'b1;
                m_fine_a = m_fine_a + 64'd1000;
                n++;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("now_a",     now_a, m_now_a());
        chk("snap_a",    snap_a, m_snap_a);
        chk("snap_hi_a", 64'(hi_a), 64'(m_snap_a[63:32]));
        chk("snap_lo_a", 64'(lo_a), 64'(m_snap_a[31:0]));
        chk("vld_a",     64'(vld_a), 64'(m_vld_a));
        chk("wrap_a",    64'(wrap_a), 64'(m_wrap_a));
        chk("now_b",     now_b, m_now_b());
        chk("snap_b",    snap_b, m_snap_b);
        chk("snap_hi_b", 64'(hi_b), 64'(m_snap_b[63:32]));
        chk("snap_lo_b", 64'(lo_b), 64'(m_snap_b[31:0]));
        chk("vld_b",     64'(vld_b), 64'(m_vld_b));
        chk("wrap_b",    64'(wrap_b), 64'd0);
        chk("rem_b",     64'(dut_b.u_div.rem), (n * 400) % 1000);
    endtask

    // Drive one cycle of inputs after the edge, then compare at the following falling edge.
    task automatic cyc(input logic e, input logic c, input logic r, input logic s);
        @(posedge clk);
        #2;
        en = e; clr = c; req = r; sel = s;
        @(negedge clk);
        #0;
        compare_all();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        cyc(0, 0, 0, 1);
        chk("rst_now",  now_a, 64'd0);
        chk("rst_snap", snap_a, 64'd0);
        chk("rst_vld",  64'(vld_a), 64'd0);
        chk("rst_wrap", 64'(wrap_a), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // 400/1000 instance: 3 and 5 enabled cycles
        repeat (3) cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("a_coarse3", now_a, 64'd3);
        chk("b_coarse3", now_b, 64'd1);
        chk("b_rem3",    64'(dut_b.u_div.rem), 64'd200);
        repeat (2) cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("a_fine5",   now_a, 64'd5000);
        chk("b_fine5",   now_b, 64'd2000);
        cyc(0, 0, 0, 0);
        chk("a_coarse5", now_a, 64'd5);
        chk("b_coarse5", now_b, 64'd2);
        chk("b_rem5",    64'(dut_b.u_div.rem), 64'd0);

        // snapshot at fine=3000
        cyc(0, 1, 0, 1);
        repeat (3) cyc(1, 0, 0, 1);
        cyc(0, 0, 1, 1);
        chk("pre_snap_now", now_a, 64'd3000);
        cyc(0, 0, 0, 1);
        chk("snap3000",    snap_a, 64'd3000);
        chk("snap_hi3000", 64'(hi_a), 64'd0);
        chk("snap_lo3000", 64'(lo_a), 64'd3000);
        chk("snap_vld1",   64'(vld_a), 64'd1);
        cyc(0, 0, 0, 1);
        chk("snap_vld0",   64'(vld_a), 64'd0);
        chk("snap_hold",   snap_a, 64'd3000);

        // back-to-back requests while counting, then a coarse-unit snapshot
        cyc(1, 0, 1, 1);
        cyc(1, 0, 1, 1);
        chk("b2b_snap0", snap_a, 64'd3000);
        cyc(0, 0, 0, 1);
        chk("b2b_snap1", snap_a, 64'd4000);
        chk("b2b_vld1",  64'(vld_a), 64'd1);
        chk("b2b_now",   now_a, 64'd5000);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        chk("snap_coarse", snap_a, 64'd5);

        // clear and request together at fine=7000
        cyc(0, 1, 0, 1);
        repeat (7) cyc(1, 0, 0, 1);
        cyc(1, 1, 1, 1);
        chk("pre_clr_now", now_a, 64'd7000);
        cyc(0, 0, 0, 1);
        chk("clr_snap", snap_a, 64'd7000);
        chk("clr_now",  now_a, 64'd0);
        chk("clr_vld",  64'(vld_a), 64'd1);
        chk("clr_wrap", 64'(wrap_a), 64'd0);

        // wrap past 2^64-1 from a preloaded fine value
        cyc(0, 0, 0, 1);
        #1;
        force dut_a.fine = 64'hFFFF_FFFF_FFFF_FE0C;
        preload_val = 64'hFFFF_FFFF_FFFF_FE0C;
        preload_ev  = 1'b1;
        #1;
        release dut_a.fine;
        preload_ev = 1'b0;
        #1;
        chk("preload_now", now_a, 64'hFFFF_FFFF_FFFF_FE0C);
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("wrap_now", now_a, 64'd500);
        chk("wrap_set", 64'(wrap_a), 64'd1);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 1);
        chk("wrap_after_clr", 64'(wrap_a), 64'd1);
        chk("now_after_clr",  now_a, 64'd0);

        // asynchronous reset between edges with a request pending
        repeat (9) cyc(1, 0, 0, 1);
        cyc(0, 0, 1, 1);
        chk("pre_rst_now", now_a, 64'd9000);
        cyc(0, 0, 0, 1);
        chk("pre_rst_snap", snap_a, 64'd9000);
        cyc(1, 0, 1, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_now",  now_a, 64'd0);
        chk("arst_snap", snap_a, 64'd0);
        chk("arst_lo",   64'(lo_a), 64'd0);
        chk("arst_vld",  64'(vld_a), 64'd0);
        chk("arst_wrap", 64'(wrap_a), 64'd0);
        chk("arst_now_b", now_b, 64'd0);
        en = 1'b0; req = 1'b0;
        repeat (2) cyc(0, 0, 0, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("post_rst_now", now_a, 64'd1000);
        chk("post_rst_vld", 64'(vld_a), 64'd0);
        chk("post_rst_b",   now_b, 64'd400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sim_time.md
SIM_TIME -- requirements
Module: sim_time

Interface
REQ-001 Parameter PERIOD_FINE, default 1000: fine-time units (ps) added per enabled clock cycle; legal range 1..COARSE_DIV.
REQ-002 Parameter COARSE_DIV, default 1000: fine units per coarse unit (ps per ns); legal range 1..2^31-1.
REQ-003 clk_i  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1: reset; asynchronous, active-low.
REQ-005 en_i  input  1: count enable; time advances only in cycles where en_i=1.
REQ-006 clr_i  input  1: synchronous clear of all time state.
REQ-007 fine_sel_i  input  1: unit select; 1=fine units, 0=coarse units.
REQ-008 req_i  input  1: snapshot request strobe.
REQ-009 now_o  output  64: live time in the selected unit, combinational from registered counters.
REQ-010 snap_o  output  64: registered snapshot of time in the selected unit.
REQ-011 snap_hi_o  output  32: snap_o[63:32].
REQ-012 snap_lo_o  output  32: snap_o[31:0].
REQ-013 snap_valid_o  output  1: one-cycle pulse marking a new snapshot.
REQ-014 wrap_o  output  1: sticky flag, fine counter has wrapped past 2^64-1.

Function
REQ-015 Fine counter (64 bit): each edge with en_i=1 and clr_i=0 it SHALL add PERIOD_FINE, modulo 2^64.
REQ-016 Coarse counter (64 bit) with remainder register rem (32 bit, always < COARSE_DIV): on the same enabled edge, sum=rem+PERIOD_FINE; if sum>=COARSE_DIV then coarse+=1 and rem=sum-COARSE_DIV, else rem=sum.
REQ-017 Invariant: coarse*COARSE_DIV+rem SHALL equal fine modulo 2^64 at all times before any wrap.
REQ-018 now_o SHALL equal fine when fine_sel_i=1, else coarse; zero-latency select on the current register values.
REQ-019 On an edge with req_i=1, snap_o SHALL load the now_o value present before that edge (pre-increment, pre-clear) and snap_valid_o SHALL be 1 in the following cycle only.
REQ-020 Back-to-back req_i SHALL produce one snapshot and one valid pulse per request cycle; snap_o holds its value between requests.
REQ-021 clr_i=1 SHALL zero fine, coarse and rem at the edge, with priority over en_i; it SHALL NOT clear snap_o or wrap_o.
REQ-022 clr_i and req_i together: the snapshot captures the pre-clear value.
REQ-023 wrap_o SHALL set on the edge where fine+PERIOD_FINE carries out of bit 63, and stays set until reset.
REQ-024 en_i=0 SHALL hold fine, coarse and rem unchanged; req_i still functions.
REQ-025 Illegal parameters (PERIOD_FINE=0, PERIOD_FINE>COARSE_DIV, COARSE_DIV=0) SHALL cause an elaboration-time error.

Reset
REQ-026 rst_ni=0 SHALL asynchronously force fine=0, coarse=0, rem=0, snap_o=0, snap_valid_o=0, wrap_o=0.
REQ-027 Reset asserted mid-operation SHALL abort any pending snapshot; the first enabled edge after release increments from 0.

Structure
REQ-028 Package sim_time_pkg SHALL hold typedef time_t (logic [63:0]) and the default PERIOD_FINE/COARSE_DIV constants.
REQ-029 The coarse counter plus remainder logic SHALL be a sub-module sim_time_div, parameterised by PERIOD_FINE and COARSE_DIV, with en, clr and coarse-value ports.

Verification
REQ-030 Reset, en_i=1 for 5 cycles, fine_sel_i=1 -> now_o=5000; fine_sel_i=0 -> now_o=5.
REQ-031 PERIOD_FINE=400, COARSE_DIV=1000, 5 enabled cycles -> fine=2000, coarse=2, rem=0; after 3 cycles coarse=1, rem=200.
REQ-032 req_i pulse when fine=3000, fine_sel_i=1 -> next cycle snap_o=3000, snap_hi_o=0, snap_lo_o=3000, snap_valid_o=1 for exactly one cycle.
REQ-033 clr_i and req_i in the same cycle at fine=7000 -> snap_o=7000, fine=0 afterwards, wrap_o unchanged.
REQ-034 Force fine to 2^64-500 (via PERIOD_FINE=1000 run from a preload backdoor), one enabled cycle -> fine=500, wrap_o=1, remains 1 after clr_i; cleared only by rst_ni.
REQ-035 rst_ni asserted asynchronously between edges with fine=9000 -> all outputs 0 immediately, before the next clk_i edge.
